// File: rtl/tile_bg_renderer.sv
// Scrolling tile-map background renderer: three-stage pixel pipeline from
// VGA timing to RGB444, with map and pixel memory lookups in stages 1 and 2.
module tile_bg_renderer #(
  parameter int unsigned TILE_BITS    = 4,
  parameter int unsigned MAP_COL_BITS = 8,
  parameter int unsigned MAP_ROW_BITS = 5,
  parameter logic [11:0] BG_COLOR     = 12'h6AF,
  parameter logic [11:0] TRANSPARENT  = 12'hF0F,
  parameter int unsigned LATCH_LINE   = 480
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [9:0]  hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blnk_in,
  input  logic [11:0] scroll_x,
  output logic [12:0] map_addr,
  input  logic [7:0]  map_data,
  output logic [15:0] tile_addr,
  input  logic [11:0] tile_data,
  output logic [9:0]  hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blnk_out,
  output logic [11:0] rgb_out
);

  localparam int unsigned MAP_AW  = MAP_ROW_BITS + MAP_COL_BITS;
  localparam int unsigned TILE_AW = 8 + 2 * TILE_BITS;

  logic [11:0]          scroll_reg;
  logic [11:0]          wx_c;
  logic [TILE_BITS-1:0] px1, py1;
  logic                 empty2;

  // Delay-line taps after stage 1 and stage 2.
  logic [9:0] hc1, hc2, vc1, vc2;
  logic       hs1, hs2, vs1, vs2, bl1, bl2;

  // World x of the current pixel; wraps modulo 4096.
  assign wx_c = scroll_reg + 12'(hcount_in);

  // Sample scroll once per frame at the start of vertical blank.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      scroll_reg <= '0;
    end else if (hcount_in == 10'd0 && vcount_in == 10'(LATCH_LINE)) begin
      scroll_reg <= scroll_x;
    end
  end

  // Stage 1: tile-map address plus in-tile pixel coordinates.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      map_addr <= '0;
      px1      <= '0;
      py1      <= '0;
    end else begin
      map_addr <= MAP_AW'({vcount_in[TILE_BITS +: MAP_ROW_BITS],
                           wx_c[TILE_BITS +: MAP_COL_BITS]});
      px1      <= wx_c[TILE_BITS-1:0];
      py1      <= vcount_in[TILE_BITS-1:0];
    end
  end

  // Stage 2: pixel-memory address from the returned tile index.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      tile_addr <= '0;
      empty2    <= 1'b0;
    end else begin
      tile_addr <= TILE_AW'({map_data, py1, px1});
      empty2    <= (map_data == 8'd0);
    end
  end

  // Stage 3: colour selection with blanking, empty-tile and key-colour handling.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      rgb_out <= '0;
    end else if (!bl2) begin
      rgb_out <= 12'h000;
    end else if (empty2 || tile_data == TRANSPARENT) begin
      rgb_out <= BG_COLOR;
    end else begin
      rgb_out <= tile_data;
    end
  end

  // Three-deep delay line keeping timing aligned with rgb_out.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hc1 <= '0; vc1 <= '0; hs1 <= 1'b0; vs1 <= 1'b0; bl1 <= 1'b0;
      hc2 <= '0; vc2 <= '0; hs2 <= 1'b0; vs2 <= 1'b0; bl2 <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      blnk_out   <= 1'b0;
    end else begin
      hc1 <= hcount_in; vc1 <= vcount_in; hs1 <= hsync_in; vs1 <= vsync_in; bl1 <= blnk_in;
      hc2 <= hc1;       vc2 <= vc1;       hs2 <= hs1;      vs2 <= vs1;      bl2 <= bl1;
      hcount_out <= hc2;
      vcount_out <= vc2;
      hsync_out  <= hs2;
      vsync_out  <= vs2;
      blnk_out   <= bl2;
    end
  end

endmodule

// File: doc/tile_bg_renderer.md
Name: tile_bg_renderer

Overview:
- Sits directly downstream of the VGA timing generator and consumes its pixel counters, syncs and active-video flag.
- Renders the scrolling tile-map background for the Mario playfield.
- Looks up a tile index in an external tile-map memory, then a 12-bit colour in an external tile-pixel memory.
- Outputs RGB plus delayed timing, all aligned to the same cycle, for the next stage (sprite overlay / VGA pins).

Parameters:
- TILE_BITS, 4, log2 of tile edge in pixels (16x16 tiles).
- MAP_COL_BITS, 8, log2 of map width in tiles (256 columns = 4096 px world).
- MAP_ROW_BITS, 5, log2 of map height in tiles (32 rows).
- BG_COLOR, 12'h6AF, sky colour for tile 0 and transparent pixels.
- TRANSPARENT, 12'hF0F, key colour in tile memory meaning "show BG_COLOR".
- LATCH_LINE, 480, vcount value on which scroll is sampled (first vertical-blank line).

Ports:
- pclk  in  1  pixel clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hcount_in  in  10  horizontal pixel counter.
- vcount_in  in  10  vertical line counter.
- hsync_in  in  1  horizontal sync, passed through.
- vsync_in  in  1  vertical sync, passed through.
- blnk_in  in  1  1 = active display area, 0 = blanking.
- scroll_x  in  12  world x of the leftmost visible pixel, from game logic.
- map_addr  out  13  tile-map read address {row, col}.
- map_data  in  8  tile index; valid 1 cycle after map_addr.
- tile_addr  out  16  pixel-memory read address {tile_id, py, px}.
- tile_data  in  12  RGB444 pixel; valid 1 cycle after tile_addr.
- hcount_out  out  10  hcount_in delayed 3 cycles.
- vcount_out  out  10  vcount_in delayed 3 cycles.
- hsync_out  out  1  hsync_in delayed 3 cycles.
- vsync_out  out  1  vsync_in delayed 3 cycles.
- blnk_out  out  1  blnk_in delayed 3 cycles.
- rgb_out  out  12  pixel colour, aligned with the *_out timing.

Behaviour:
- Reset (asynchronous): all outputs and pipeline registers 0, including rgb_out, map_addr, tile_addr, all *_out, and scroll_reg. Reset mid-frame clears the pipeline. First valid output appears 3 cycles after rst falls; no memory reads are held over.
- Scroll latch: scroll_reg <= scroll_x when hcount_in==0 and vcount_in==LATCH_LINE. It is otherwise held, so scroll changes never tear mid-frame.
- Stage 1 (cycle 1):
  - wx = scroll_reg + hcount_in, 12-bit with natural modulo-4096 wrap (the world wraps horizontally).
  - map_addr <= {vcount_in[8:4], wx[11:4]}.
  - Registers px1 = wx[3:0] and py1 = vcount_in[3:0].
  - Timing signals and counters enter a 3-deep delay line.
- Stage 2 (cycle 2): map_data valid.
  - tile_addr <= {map_data, py1, px1}.
  - empty2 <= (map_data == 0).
  - The remaining delay-line signals advance.
- Stage 3 (cycle 3): tile_data valid. rgb_out is:
  - 0 if the delayed blnk is 0;
  - else BG_COLOR if empty2 was set or tile_data == TRANSPARENT;
  - else tile_data.
- Latency: fixed 3 cycles on every signal, so *_out and rgb_out are cycle-aligned. The block has no stall and no handshake; it produces one pixel per clock.
- Address generation continues during blanking, which is harmless. Rows beyond 29 (vcount ≥ 480) are read but masked to 0 by blnk.
- Line/frame wrap: hcount/vcount wrap handling is entirely upstream. This block is stateless across pixels except for scroll_reg.
- Simultaneous latch condition and reset: reset wins.

Test Plan:
- Reset release: hold rst for 5 cycles, then drive hcount=0, vcount=0, blnk=1. All outputs must be 0 during reset and until cycle 3. At cycle 3, hcount_out=0 and blnk_out=1.
- Alignment: scroll=0, map row0 col0=5, tile 5 pixel (0,0)=12'h123. Drive hcount=0, vcount=0, blnk=1.
  - map_addr=0 at cycle 1.
  - tile_addr=16'h0500 at cycle 2.
  - rgb_out=12'h123 at cycle 3, with hcount_out=0.
- Transparency and empty tile:
  - Tile 7 pixel = 12'hF0F gives rgb_out = 12'h6AF.
  - Map entry 0 with tile_data 12'h000 gives rgb_out = 12'h6AF.
- Blanking: blnk_in=0 with opaque pixel 12'hFFF gives rgb_out=0, while hsync/vsync still pass through delayed by 3 cycles.
- Scroll latch timing and wrap:
  - Change scroll_x to 12'hFF8 mid-frame (vcount=100); map_addr is unaffected.
  - After hcount=0, vcount=480, hcount=10 gives wx=12'h002 and map_addr col=0, px=2.
  - hcount=7 gives col=255, px=15.
- Mid-frame reset: pulse rst at vcount=200, hcount=300. Outputs must go 0 immediately (asynchronously) and scroll_reg must return to 0 (the next frame renders from wx=hcount).
